// File: rtl/serial_deserializer_if.sv
// Handshake/data bundle between the serial line driver and the deserializer.
// The master side drives the line, the strobe and the consumer ready.
interface serial_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             serial_in;
    logic             bit_en;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        output serial_in,
        output bit_en,
        output word_ready,
        input  word_out,
        input  word_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  serial_in,
        input  bit_en,
        input  word_ready,
        output word_out,
        output word_valid,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/serial_deserializer.sv
// Framed serial receiver: start 0, WIDTH data bits LSB first, stop 1.
// Received words sit in a valid/ready output register; framing errors and overruns are flagged.
module serial_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input logic                  input_clock2_slow_clk_2,
    input logic                  input_push_button1_reset_1,
    serial_deserializer_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CntW-1:0]  bit_cnt_q;

    always_ff @(posedge input_clock2_slow_clk_2 or posedge input_push_button1_reset_1) begin
        if (input_push_button1_reset_1) begin
            state_q        <= StIdle;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            bus.word_out   <= '0;
            bus.word_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            // Accept clears valid; a same-edge load below overrides it.
            if (bus.word_valid && bus.word_ready) begin
                bus.word_valid <= 1'b0;
            end
            if (bus.bit_en) begin
                unique case (state_q)
                    StIdle: begin
                        if (!bus.serial_in) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                            bus.busy  <= 1'b1;
                        end
                    end
                    StData: begin
                        shift_q   <= {bus.serial_in, shift_q[WIDTH-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CntW'(WIDTH - 1)) begin
                            state_q <= StStop;
                        end
                    end
                    StStop: begin
                        state_q  <= StIdle;
                        bus.busy <= 1'b0;
                        if (bus.serial_in) begin
                            if (!bus.word_valid || bus.word_ready) begin
                                bus.word_out   <= shift_q;
                                bus.word_valid <= 1'b1;
                            end else begin
                                bus.overrun <= 1'b1;
                            end
                        end else begin
                            bus.frame_err <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboarded bench: the driver models each frame at transaction level and queues loaded words;
// a negedge monitor pops on every accept and compares flags against the model every cycle.
module tb_serial_deserializer;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;

    serial_deserializer_if #(.WIDTH(W)) bus ();

    serial_deserializer #(.WIDTH(W)) dut (
        .input_clock2_slow_clk_2   (clk),
        .input_push_button1_reset_1(rst),
        .bus                       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         m_valid, m_ovr, m_busy, m_ferr;
    logic [W-1:0] m_word;
    bit           mon_en = 1'b0;
    int           rdy_mode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
        m_ferr  = 1'b0;
        m_word  = '0;
        exp_q.delete();
    endtask

    function automatic logic pick_rdy(input bit is_stop);
        case (rdy_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return is_stop;
        endcase
    endfunction

    // role: 0 = idle/data/gap, 1 = start sample, 2 = stop sample
    task automatic tick(input logic s, input logic en, input logic rdy, input int role,
                        input logic [W-1:0] data);
        logic load;
        bus.serial_in  = s;
        bus.bit_en     = en;
        bus.word_ready = rdy;
        @(posedge clk);
        load   = 1'b0;
        m_ferr = 1'b0;
        if (en && role == 1) m_busy = 1'b1;
        if (en && role == 2) begin
            m_busy = 1'b0;
            if (s) begin
                if (!m_valid || rdy) load = 1'b1;
                else m_ovr = 1'b1;
            end else begin
                m_ferr = 1'b1;
            end
        end
        if (load) begin
            m_valid = 1'b1;
            m_word  = data;
            exp_q.push_back(data);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic stop_bit, input int gap);
        logic b;
        int   role;
        for (int i = 0; i < W + 2; i++) begin
            b    = (i == 0) ? 1'b0 : (i <= W) ? data[i-1] : stop_bit;
            role = (i == 0) ? 1 : (i == W + 1) ? 2 : 0;
            for (int g = 0; g < gap; g++) tick(b, 1'b0, pick_rdy(1'b0), 0, data);
            tick(b, 1'b1, pick_rdy(role == 2), role, data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, pick_rdy(1'b0), 0, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("word_valid", 32'(bus.word_valid), 32'(m_valid));
            chk("overrun", 32'(bus.overrun), 32'(m_ovr));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
            chk("word_out_hold", 32'(bus.word_out), 32'(m_word));
            if (bus.word_valid && bus.word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", 32'(bus.word_out), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_word", 32'(bus.word_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.serial_in  = 1'b1;
        bus.bit_en     = 1'b0;
        bus.word_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.word_valid), 32'd0);
        chk("reset_word", 32'(bus.word_out), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: frame 1,0,1,1 LSB first -> 4'hD
        rdy_mode = 1;
        idle(2);
        send_frame(4'hD, 1'b1, 0);
        chk("t1_word", 32'(bus.word_out), 32'hD);
        idle(2);

        // 2: strobe every 3rd cycle
        send_frame(4'hD, 1'b1, 2);
        chk("t2_word", 32'(bus.word_out), 32'hD);
        idle(2);

        // 3: bad stop bit
        rdy_mode = 0;
        send_frame(4'hF, 1'b0, 0);
        chk("t3_valid", 32'(bus.word_valid), 32'd0);
        chk("t3_word", 32'(bus.word_out), 32'hD);
        idle(2);

        // 4: overrun, then a single accept
        send_frame(4'h5, 1'b1, 0);
        send_frame(4'hA, 1'b1, 0);
        chk("t4_word", 32'(bus.word_out), 32'h5);
        chk("t4_overrun", 32'(bus.overrun), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 0, '0);
        chk("t4_valid_after_accept", 32'(bus.word_valid), 32'd0);
        chk("t4_overrun_sticky", 32'(bus.overrun), 32'd1);

        // 5: reset mid-frame with a held word
        send_frame(4'h7, 1'b1, 0);
        tick(1'b0, 1'b1, 1'b0, 1, '0);
        tick(1'b1, 1'b1, 1'b0, 0, '0);
        tick(1'b0, 1'b1, 1'b0, 0, '0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_valid", 32'(bus.word_valid), 32'd0);
        chk("t5_overrun", 32'(bus.overrun), 32'd0);
        chk("t5_word", 32'(bus.word_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        send_frame(4'h3, 1'b1, 0);
        chk("t5_word_after", 32'(bus.word_out), 32'h3);

        // 6: accept and load on the same edge
        tick(1'b1, 1'b1, 1'b1, 0, '0);
        send_frame(4'h6, 1'b1, 0);
        rdy_mode = 3;
        send_frame(4'h9, 1'b1, 0);
        chk("t6_word", 32'(bus.word_out), 32'h9);
        chk("t6_valid", 32'(bus.word_valid), 32'd1);
        chk("t6_overrun", 32'(bus.overrun), 32'd0);

        // Random frames, gaps, idle bits and ready
        rdy_mode = 2;
        for (int n = 0; n < 150; n++) begin
            send_frame(W'($urandom), ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                tick(1'b1, 1'($urandom_range(0, 1)), pick_rdy(1'b0), 0, '0);
            end
        end

        rdy_mode = 1;
        idle(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
